// File: rtl/pgm_rom_pkg.sv
// rtl/pgm_rom_pkg.sv - shared widths, sequencing states and loader word type for the program ROM arbiter
package pgm_rom_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ld_word_t;
endpackage

// File: rtl/pgm_rom_arbiter_if.sv
// rtl/pgm_rom_arbiter_if.sv - loader, CPU fetch and ROM port bundle of the program ROM arbiter
interface pgm_rom_arbiter_if;
  import pgm_rom_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_start;
  logic              ld_done;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_start, ld_done, cpu_req, cpu_addr, mem_rdata,
    input  ld_ready, cpu_gnt, cpu_valid, cpu_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_start, ld_done, cpu_req, cpu_addr, mem_rdata,
    output ld_ready, cpu_gnt, cpu_valid, cpu_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pgm_wr_fifo.sv
// rtl/pgm_wr_fifo.sv - count-based synchronous FIFO buffering loader words ahead of ROM writes
module pgm_wr_fifo
  import pgm_rom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  ld_word_t push_word,
  input  logic     pop,
  output ld_word_t head_word,
  output logic     full,
  output logic     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  ld_word_t         mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  // a push into a full buffer is still taken when the head leaves in the same cycle
  assign push_ok   = push && (!full || pop_ok);
  assign head_word = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_word;
  end
endmodule

// File: rtl/pgm_rom_arbiter.sv
// rtl/pgm_rom_arbiter.sv - program ROM arbiter: buffered loader writes, LOAD/DRAIN/RUN sequencing, CPU fetch grants
// Define PGM_ROM_CHECKSUM_EN to add ld_checksum, the running sum of words accepted since ld_start/reset.
module pgm_rom_arbiter
  import pgm_rom_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  pgm_rom_arbiter_if.slave   arb,
  output logic               cpu_rst_n
`ifdef PGM_ROM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  ld_checksum
`endif
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q;
  ld_word_t         push_word;
  ld_word_t         head_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ld_accept;
  logic             cpu_grant;
  logic             wr_issue;
  logic             starve_hit;
  logic             cpu_valid_q;
  logic [CNT_W-1:0] starve_cnt;

  assign push_word = {arb.ld_addr, arb.ld_data};
  assign ld_accept = arb.ld_valid && !fifo_full;

  pgm_wr_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk_74a),
    .rst_n     (reset_n),
    .flush     (arb.ld_start),
    .push      (ld_accept),
    .push_word (push_word),
    .pop       (wr_issue),
    .head_word (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign starve_hit = fifo_full && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // ld_start silences the ROM port for its cycle; the buffer is being discarded anyway
  always_comb begin
    cpu_grant = 1'b0;
    wr_issue  = 1'b0;
    if (!arb.ld_start) begin
      if (state_q == ST_RUN && arb.cpu_req && !starve_hit) cpu_grant = 1'b1;
      else                                                 wr_issue  = !fifo_empty;
    end
  end

  assign arb.ld_ready  = !fifo_full;
  assign arb.cpu_gnt   = cpu_grant;
  assign arb.mem_en    = cpu_grant || wr_issue;
  assign arb.mem_we    = wr_issue;
  assign arb.mem_addr  = cpu_grant ? arb.cpu_addr : (wr_issue ? head_word.addr : '0);
  assign arb.mem_wdata = wr_issue ? head_word.data : '0;
  assign arb.cpu_valid = cpu_valid_q;
  assign arb.cpu_data  = cpu_valid_q ? arb.mem_rdata : '0;
  assign cpu_rst_n     = (state_q == ST_RUN);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      starve_cnt  <= '0;
      cpu_valid_q <= 1'b0;
    end else begin
      cpu_valid_q <= cpu_grant;
      // only back-to-back grants against a full buffer count toward starvation
      starve_cnt  <= (cpu_grant && fifo_full) ? starve_cnt + CNT_W'(1) : '0;
      if (arb.ld_start) begin
        state_q <= ST_LOAD;
      end else begin
        case (state_q)
          ST_LOAD:  if (arb.ld_done) state_q <= ST_DRAIN;
          ST_DRAIN: if (fifo_empty)  state_q <= ST_RUN;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

`ifdef PGM_ROM_CHECKSUM_EN
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n)          ld_checksum <= '0;
    else if (arb.ld_start) ld_checksum <= '0;
    else if (ld_accept)    ld_checksum <= ld_checksum + arb.ld_data;
  end
`endif
endmodule

// File: tb/tb_pgm_rom_arbiter.sv
// tb/tb_pgm_rom_arbiter.sv - self-checking bench for pgm_rom_arbiter; PGM_ROM_CHECKSUM_EN also checks ld_checksum
module tb_pgm_rom_arbiter;
  import pgm_rom_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
  } load_vec_t;

  typedef struct {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              exp_gnt;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
  } read_vec_t;

  logic clk_74a = 1'b0;
  logic reset_n;
  logic cpu_rst_n;
`ifdef PGM_ROM_CHECKSUM_EN
  logic [DATA_W-1:0] ld_checksum;
`endif

  pgm_rom_arbiter_if arb();

  pgm_rom_arbiter #(.LD_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_74a   (clk_74a),
    .reset_n   (reset_n),
    .arb       (arb),
    .cpu_rst_n (cpu_rst_n)
`ifdef PGM_ROM_CHECKSUM_EN
    ,
    .ld_checksum (ld_checksum)
`endif
  );

  always #5 clk_74a = ~clk_74a;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] rom    [0:16383];
  logic [DATA_W-1:0] golden [0:16383];
  ld_word_t          wr_q [$];
  logic [DATA_W-1:0] rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_74a);
    #1;
  endtask

  // single-port ROM, one cycle read latency
  always @(posedge clk_74a) begin
    if (arb.mem_en && arb.mem_we)  rom[arb.mem_addr] <= arb.mem_wdata;
    if (arb.mem_en && !arb.mem_we) arb.mem_rdata <= rom[arb.mem_addr];
  end

  // scoreboard: accepted words must reach the ROM in order; every cpu_valid must pair with an earlier grant
  always @(negedge clk_74a) begin
    if (!reset_n) begin
      check("no_write_in_reset", {31'd0, arb.mem_we}, 32'd0);
      wr_q.delete();
      rd_q.delete();
    end else begin
      check("we_implies_en", {31'd0, arb.mem_we & ~arb.mem_en}, 32'd0);
      if (arb.cpu_valid) begin
        check("valid_has_grant", {31'd0, rd_q.size() != 0}, 32'd1);
        if (rd_q.size() != 0) check("cpu_data", {16'd0, arb.cpu_data}, {16'd0, rd_q.pop_front()});
      end
      if (arb.cpu_gnt) begin
        check("gnt_mem_en", {31'd0, arb.mem_en}, 32'd1);
        check("gnt_mem_addr", {18'd0, arb.mem_addr}, {18'd0, arb.cpu_addr});
        rd_q.push_back(golden[arb.cpu_addr]);
      end
      if (arb.mem_en && arb.mem_we) begin
        check("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          ld_word_t w;
          w = wr_q.pop_front();
          check("write_addr", {18'd0, arb.mem_addr}, {18'd0, w.addr});
          check("write_data", {16'd0, arb.mem_wdata}, {16'd0, w.data});
        end
      end
      if (arb.ld_start) begin
        wr_q.delete();
      end else if (arb.ld_valid && arb.ld_ready) begin
        wr_q.push_back({arb.ld_addr, arb.ld_data});
        golden[arb.ld_addr] = arb.ld_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    load_vec_t lv [4];
    read_vec_t rv [5];
    int sent;
    int gnt_full;
    int first_forced_gnts;
    int full_at_sent;
    bit seen_full;
    bit forced;
    bit acc;

    reset_n      = 1'b0;
    arb.ld_valid = 1'b0;
    arb.ld_addr  = '0;
    arb.ld_data  = '0;
    arb.ld_start = 1'b0;
    arb.ld_done  = 1'b0;
    arb.cpu_req  = 1'b0;
    arb.cpu_addr = '0;

    for (int i = 0; i < 4; i++) begin
      lv[i].addr      = ADDR_W'(i);
      lv[i].data      = DATA_W'((i + 1) * 16'h1111);
      lv[i].exp_we    = (i > 0);
      lv[i].exp_waddr = ADDR_W'(i > 0 ? i - 1 : 0);
    end
    rv[0] = '{req: 1'b1, addr: 14'd2, exp_gnt: 1'b1, exp_valid: 1'b0, exp_data: 16'h0000};
    rv[1] = '{req: 1'b0, addr: 14'd0, exp_gnt: 1'b0, exp_valid: 1'b1, exp_data: 16'h3333};
    rv[2] = '{req: 1'b1, addr: 14'd0, exp_gnt: 1'b1, exp_valid: 1'b0, exp_data: 16'h0000};
    rv[3] = '{req: 1'b1, addr: 14'd3, exp_gnt: 1'b1, exp_valid: 1'b1, exp_data: 16'h1111};
    rv[4] = '{req: 1'b0, addr: 14'd0, exp_gnt: 1'b0, exp_valid: 1'b1, exp_data: 16'h4444};

    // reset values
    repeat (2) @(posedge clk_74a);
    @(negedge clk_74a);
    check("rst_ld_ready",  {31'd0, arb.ld_ready},  32'd1);
    check("rst_cpu_gnt",   {31'd0, arb.cpu_gnt},   32'd0);
    check("rst_cpu_valid", {31'd0, arb.cpu_valid}, 32'd0);
    check("rst_cpu_data",  {16'd0, arb.cpu_data},  32'd0);
    check("rst_mem_en",    {31'd0, arb.mem_en},    32'd0);
    check("rst_mem_we",    {31'd0, arb.mem_we},    32'd0);
    check("rst_mem_addr",  {18'd0, arb.mem_addr},  32'd0);
    check("rst_mem_wdata", {16'd0, arb.mem_wdata}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n},     32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // program load: four words, each written the cycle after acceptance
    for (int i = 0; i < 4; i++) begin
      arb.ld_valid = 1'b1;
      arb.ld_addr  = lv[i].addr;
      arb.ld_data  = lv[i].data;
      @(negedge clk_74a);
      check("load_ld_ready", {31'd0, arb.ld_ready}, 32'd1);
      check("load_mem_we", {31'd0, arb.mem_we}, {31'd0, lv[i].exp_we});
      if (lv[i].exp_we) check("load_mem_addr", {18'd0, arb.mem_addr}, {18'd0, lv[i].exp_waddr});
      check("load_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      cyc();
    end
    arb.ld_valid = 1'b0;
    arb.ld_done  = 1'b1;
    @(negedge clk_74a);
    check("last_write_we", {31'd0, arb.mem_we}, 32'd1);
    check("last_write_addr", {18'd0, arb.mem_addr}, 32'd3);
    check("done_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    cyc();
    arb.ld_done = 1'b0;
    @(negedge clk_74a);
    check("drain_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("drain_mem_en", {31'd0, arb.mem_en}, 32'd0);
    cyc();
    @(negedge clk_74a);
    check("run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    #1;
    check("load_all_written", wr_q.size(), 32'd0);
    for (int i = 0; i < 4; i++) check("rom_after_load", {16'd0, rom[i]}, {16'd0, lv[i].data});
    cyc();

    // CPU fetches
    for (int i = 0; i < 5; i++) begin
      arb.cpu_req  = rv[i].req;
      arb.cpu_addr = rv[i].addr;
      @(negedge clk_74a);
      check("rd_cpu_gnt", {31'd0, arb.cpu_gnt}, {31'd0, rv[i].exp_gnt});
      check("rd_mem_en", {31'd0, arb.mem_en}, {31'd0, rv[i].exp_gnt});
      check("rd_cpu_valid", {31'd0, arb.cpu_valid}, {31'd0, rv[i].exp_valid});
      if (rv[i].exp_valid) check("rd_cpu_data", {16'd0, arb.cpu_data}, {16'd0, rv[i].exp_data});
      cyc();
    end

    // starvation: CPU hammers while five loader words are offered into a depth-4 buffer
    sent = 0; gnt_full = 0; first_forced_gnts = -1; full_at_sent = -1;
    seen_full = 1'b0; forced = 1'b0;
    arb.cpu_req  = 1'b1;
    arb.cpu_addr = 14'd1;
    arb.ld_valid = 1'b1;
    arb.ld_addr  = 14'd8;
    arb.ld_data  = 16'hA000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_74a);
      if (!arb.ld_ready && !seen_full) begin
        seen_full    = 1'b1;
        full_at_sent = sent;
      end
      if (seen_full && !forced) begin
        if (arb.cpu_gnt) begin
          gnt_full++;
        end else if (arb.mem_we) begin
          forced            = 1'b1;
          first_forced_gnts = gnt_full;
          check("forced_mem_en", {31'd0, arb.mem_en}, 32'd1);
        end
      end
      acc = arb.ld_valid && arb.ld_ready;
      cyc();
      if (acc) begin
        sent++;
        if (sent < 5) begin
          arb.ld_addr = ADDR_W'(8 + sent);
          arb.ld_data = DATA_W'(16'hA000 + sent);
        end else begin
          arb.ld_valid = 1'b0;
        end
      end
    end
    check("full_at_entries", full_at_sent, 32'd4);
    check("grants_before_forced", first_forced_gnts, 32'd8);
    check("all_five_accepted", sent, 32'd5);
    arb.cpu_req = 1'b0;
    for (int w = 0; w < 20 && wr_q.size() != 0; w++) cyc();
    check("starve_drained", wr_q.size(), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) check("rom_starve_word", {16'd0, rom[8 + i]}, 32'hA000 + i);

    // ld_start together with ld_done while two words are buffered
    arb.cpu_req  = 1'b1;
    arb.cpu_addr = 14'd0;
    for (int i = 0; i < 2; i++) begin
      arb.ld_valid = 1'b1;
      arb.ld_addr  = ADDR_W'(20 + i);
      arb.ld_data  = DATA_W'(16'hBEE0 + i);
      cyc();
    end
    arb.ld_valid = 1'b0;
    arb.ld_start = 1'b1;
    arb.ld_done  = 1'b1;
    cyc();
    arb.ld_start = 1'b0;
    arb.ld_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_74a);
      check("restart_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check("restart_mem_en", {31'd0, arb.mem_en}, 32'd0);
      check("restart_cpu_gnt", {31'd0, arb.cpu_gnt}, 32'd0);
      check("restart_ld_ready", {31'd0, arb.ld_ready}, 32'd1);
      cyc();
    end
    arb.cpu_req = 1'b0;
    arb.ld_done = 1'b1;
    cyc();
    arb.ld_done = 1'b0;
    cyc();
    @(negedge clk_74a);
    check("rerun_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    cyc();

    // reset with three words buffered behind CPU traffic
    arb.cpu_req  = 1'b1;
    arb.cpu_addr = 14'd3;
    for (int i = 0; i < 3; i++) begin
      arb.ld_valid = 1'b1;
      arb.ld_addr  = ADDR_W'(40 + i);
      arb.ld_data  = DATA_W'(16'h5550 + i);
      cyc();
    end
    arb.ld_valid = 1'b0;
    reset_n      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_74a);
      check("inrst_mem_we", {31'd0, arb.mem_we}, 32'd0);
      check("inrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      cyc();
    end
    reset_n     = 1'b1;
    arb.cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_74a);
      check("postrst_ld_ready", {31'd0, arb.ld_ready}, 32'd1);
      check("postrst_mem_en", {31'd0, arb.mem_en}, 32'd0);
      cyc();
    end

`ifdef PGM_ROM_CHECKSUM_EN
    arb.ld_valid = 1'b1;
    arb.ld_addr  = 14'd30;
    arb.ld_data  = 16'hFFFF;
    @(negedge clk_74a);
    check("checksum_after_reset", {16'd0, ld_checksum}, 32'd0);
    cyc();
    arb.ld_addr = 14'd31;
    arb.ld_data = 16'h0002;
    cyc();
    arb.ld_valid = 1'b0;
    @(negedge clk_74a);
    check("checksum_wrap", {16'd0, ld_checksum}, 32'h0001);
    cyc();
    arb.ld_start = 1'b1;
    cyc();
    arb.ld_start = 1'b0;
    @(negedge clk_74a);
    check("checksum_cleared", {16'd0, ld_checksum}, 32'd0);
    cyc();
`endif

    for (int w = 0; w < 20 && wr_q.size() != 0; w++) cyc();
    check("final_writes_drained", wr_q.size(), 32'd0);
    cyc();
    check("final_reads_done", rd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pgm_rom_arbiter.md
PGM_ROM_ARBITER -- requirements
Module: pgm_rom_arbiter

Interface
REQ-001 SHALL have parameter LD_FIFO_DEPTH, default 4, meaning loader write-buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the max consecutive CPU grants while the FIFO is full.
REQ-003 SHALL have port clk_74a, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports ld_valid (in, 1), ld_ready (out, 1), ld_addr (in, 14), ld_data (in, 16): the loader word-write handshake.
REQ-006 SHALL have ports ld_start (in, 1) and ld_done (in, 1): single-cycle pulses bracketing a program load.
REQ-007 SHALL have ports cpu_req (in, 1), cpu_addr (in, 14), cpu_gnt (out, 1), cpu_valid (out, 1), cpu_data (out, 16): the CPU fetch port.
REQ-008 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 14), mem_wdata (out, 16), mem_rdata (in, 16): a single-port ROM with 1-cycle read latency.
REQ-009 SHALL have port cpu_rst_n, output, 1: the CPU reset, active low.

Function
REQ-010 SHALL implement states LOAD, DRAIN and RUN; reset enters LOAD.
- LOAD -> DRAIN on ld_done.
- DRAIN -> RUN on the cycle the FIFO is empty and no write is issued.
- Any state -> LOAD on ld_start.
REQ-011 SHALL give ld_start priority over ld_done when both arrive in the same cycle; the resulting state is LOAD.
REQ-012 SHALL accept a loader word when ld_valid and ld_ready are both high, pushing {ld_addr, ld_data} into the FIFO; ld_ready SHALL equal "FIFO not full".
REQ-013 SHALL, in LOAD and DRAIN, issue one FIFO-head write per cycle while the FIFO is non-empty (mem_en=1, mem_we=1), hold cpu_gnt=0, and ignore cpu_req.
REQ-014 SHALL, in RUN, grant the CPU (cpu_gnt=1, mem_en=1, mem_we=0, mem_addr=cpu_addr) whenever cpu_req=1, except under REQ-016; otherwise it SHALL issue a pending FIFO write.
REQ-015 SHALL assert cpu_valid exactly one cycle after each grant, with cpu_data=mem_rdata; cpu_valid SHALL never be high without a prior grant.
REQ-016 SHALL, when the FIFO is full and STARVE_LIMIT consecutive CPU grants have occurred, force one write cycle with cpu_gnt=0, then reset the grant counter.
REQ-017 SHALL drive cpu_rst_n=0 in LOAD and DRAIN, and 1 from the first RUN cycle onward.
REQ-018 SHALL, on ld_start, discard the FIFO contents and any in-flight cpu_valid, and drive cpu_rst_n=0 in the following cycle.
REQ-019 SHALL wrap FIFO pointers modulo LD_FIFO_DEPTH; a push and a pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-020 SHALL hold mem_we=0 whenever mem_en=0.

Reset
REQ-021 SHALL, on reset, drive state=LOAD, FIFO empty, ld_ready=1, cpu_gnt=0, cpu_valid=0, cpu_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, and the starvation counter to 0.
REQ-022 SHALL, on reset asserted mid-load, drop all buffered words; no ROM write SHALL occur while reset_n=0.

Configuration
REQ-023 SHALL, with PGM_ROM_CHECKSUM_EN defined, provide output ld_checksum (16): the modulo-2^16 sum of the ld_data words accepted since the last ld_start or reset, updated the cycle after acceptance.
REQ-024 SHALL, without PGM_ROM_CHECKSUM_EN, omit the ld_checksum port and its adder entirely.

Structure
REQ-025 SHALL place the address width (14), data width (16) and state enum in the package pgm_rom_pkg.
REQ-026 SHALL implement the write buffer as sub-module pgm_wr_fifo (synchronous FIFO, count-based full/empty).

Verification
REQ-027 SHALL cover: reset; write 4 words (addr 0..3, data 0x1111..0x4444); ld_done -> ROM holds them; cpu_rst_n rises after the last write; cpu_rst_n=0 throughout.
REQ-028 SHALL cover: in RUN, cpu_req with cpu_addr=2 -> cpu_gnt the same cycle, cpu_valid and cpu_data=0x3333 one cycle later.
REQ-029 SHALL cover: in RUN, cpu_req held high while 5 loader writes are offered with depth 4 -> ld_ready drops at 4 entries; after 8 grants one forced write cycle occurs with cpu_gnt=0; all 5 words land in the ROM.
REQ-030 SHALL cover: ld_start and ld_done in the same cycle -> state LOAD, cpu_rst_n=0 next cycle, FIFO empty.
REQ-031 SHALL cover: reset asserted with 3 words buffered -> no further mem_we; after release, ld_ready=1 and the FIFO is empty.
REQ-032 SHALL cover: with PGM_ROM_CHECKSUM_EN, loading 0xFFFF and 0x0002 -> ld_checksum=0x0001.
